// File: rtl/display_capture_pkg.sv
// display_capture_pkg
//   Shared definitions for the 7-segment display path: active-low segment
//   patterns (g..a, dp excluded), the capture FSM state encoding, the debug
//   struct exported by display_capture, and small anode helpers.
//   The same pattern constants are used by the display driver.
package display_capture_pkg;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_HOLD = 1'b1
   } cap_state_t;

   // Observable internals: FSM state and captured-digit mask.
   typedef struct packed {
      cap_state_t state;
      logic [3:0] mask;
   } cap_dbg_t;

   localparam logic [3:0] AN_BLANK = 4'b1111;

   // Active-low segment patterns, bit 6 = g ... bit 0 = a.
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   // True when exactly one (active-low) anode is driven.
   function automatic logic one_cold(input logic [3:0] a);
      logic r;
      r = (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
      return r;
   endfunction

   // Position of the single active anode; only meaningful when one_cold(a).
   function automatic logic [1:0] anode_index(input logic [3:0] a);
      logic [1:0] r;
      case (a)
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/display_capture_seg7_decode.sv
// seg7_decode
//   Combinational 7-segment to hex decoder.
//   pattern : active-low segments g..a (dp not included)
//   nibble  : decoded hex digit (0 when not ok)
//   ok      : pattern is one of the sixteen hex glyphs
module seg7_decode
   import display_capture_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       ok
);

   always_comb begin
      nibble = 4'h0;
      ok     = 1'b1;
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: ok     = 1'b0;
      endcase
   end

endmodule

// File: rtl/display_capture.sv
// display_capture
//   Reconstructs the 16-bit word shown on a multiplexed 4-digit 7-segment
//   display by sniffing its anode/segment lines.
//   clk     : single clock, rising edge
//   rst     : synchronous, active-high reset
//   an      : active-low anodes, an[0] = rightmost digit
//   seg     : active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   value   : last complete word, digit for an[i] in value[4i+3:4i]
//   valid   : one-cycle pulse when value updates
//   seg_err : one-cycle pulse when a stable digit has an undecodable glyph
//   timeout : one-cycle pulse when a partial frame is discarded
//   dbg     : FSM state and captured-digit mask
//
// Handshake: there is no back-pressure; valid, seg_err and timeout are
// single-cycle strobes and value is stable between valid strobes.
//
// A digit is captured once per settle: the {an,seg} sample must stay
// unchanged for STABLE_CYCLES consecutive edges (sample held for
// STABLE_CYCLES+1 cycles) while exactly one anode is active.
module display_capture
   import display_capture_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [7:0]  seg,
   output logic [15:0] value,
   output logic        valid,
   output logic        seg_err,
   output logic        timeout,
   output cap_dbg_t    dbg
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

   // Input sample and its previous value.
   logic [3:0]    an_r, an_p;
   logic [7:0]    seg_r, seg_p;
   logic [SW-1:0] stab_cnt, stab_next;
   logic          same, cand;

   cap_state_t    state, state_next;
   logic          capture;

   logic [3:0]    nib;
   logic          dec_ok;
   logic [1:0]    idx;
   logic          accept, bad;

   logic [15:0]   shadow, shadow_n;
   logic [3:0]    mask, mask_n;
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic          fire_valid, fire_tmo;

   seg7_decode u_decode (
      .pattern (seg_r[6:0]),
      .nibble  (nib),
      .ok      (dec_ok)
   );

   assign same = (an_r == an_p) && (seg_r == seg_p);
   assign cand = one_cold(an_r);
   assign idx  = anode_index(an_r);

   // Stability counter saturates so a long hold never wraps back through
   // STABLE_CYCLES.
   always_comb begin
      stab_next = '0;
      if (same && cand) begin
         stab_next = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + SW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_WAIT;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state; capture fires only on the WAIT->HOLD edge.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         ST_WAIT: begin
            if (cand && same && (stab_next == STAB_MAX)) begin
               state_next = ST_HOLD;
               capture    = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!same) begin
               state_next = ST_WAIT;
            end
         end
         default: state_next = ST_WAIT;
      endcase
   end

   assign accept = capture && dec_ok;
   assign bad    = capture && !dec_ok;

   // Frame assembly. Completion clears the mask first so a capture on the
   // same edge would start the next frame; a capture beats a timeout.
   always_comb begin
      mask_n     = mask;
      shadow_n   = shadow;
      tmo_n      = tmo_cnt;
      fire_valid = 1'b0;
      fire_tmo   = 1'b0;
      if (mask == 4'b1111) begin
         fire_valid = 1'b1;
         mask_n     = '0;
      end
      if (accept) begin
         shadow_n[{idx, 2'b00} +: 4] = nib;
         mask_n[idx]                 = 1'b1;
         tmo_n                       = '0;
      end else if (tmo_cnt == TMO_MAX) begin
         // Saturate while idle with nothing captured; discard otherwise.
         if (mask_n != '0) begin
            fire_tmo = 1'b1;
            mask_n   = '0;
            tmo_n    = '0;
         end
      end else begin
         tmo_n = tmo_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_r     <= AN_BLANK;
         seg_r    <= 8'hFF;
         an_p     <= AN_BLANK;
         seg_p    <= 8'hFF;
         stab_cnt <= '0;
         shadow   <= '0;
         mask     <= '0;
         tmo_cnt  <= '0;
         value    <= '0;
         valid    <= 1'b0;
         seg_err  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         an_r     <= an;
         seg_r    <= seg;
         an_p     <= an_r;
         seg_p    <= seg_r;
         stab_cnt <= stab_next;
         shadow   <= shadow_n;
         mask     <= mask_n;
         tmo_cnt  <= tmo_n;
         valid    <= fire_valid;
         seg_err  <= bad;
         timeout  <= fire_tmo;
         if (fire_valid) begin
            value <= shadow;
         end
      end
   end

   assign dbg.state = state;
   assign dbg.mask  = mask;

endmodule
